// File: rtl/hazard_scoreboard_if.sv
// Decode-to-scoreboard bundle: decode instruction fields in, stall/issue and
// scoreboard status out.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int MAX_LAT  = 8,
  parameter int PERF_W   = 32
);
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int LAT_W  = $clog2(MAX_LAT + 1);

  logic              d_valid;
  logic [REG_AW-1:0] d_rs1;
  logic [REG_AW-1:0] d_rs2;
  logic              d_rs1_used;
  logic              d_rs2_used;
  logic [REG_AW-1:0] d_rd;
  logic              d_rd_we;
  logic [LAT_W-1:0]  d_lat;
  logic              d_long;
  logic              flush;
  logic              stall;
  logic              issue;
  logic [NUM_REGS-1:0] pending;
  logic              long_busy;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output d_valid, d_rs1, d_rs2, d_rs1_used, d_rs2_used, d_rd, d_rd_we,
           d_lat, d_long, flush,
    input  stall, issue, pending, long_busy, stall_cycles
  );

  modport slave (
    input  d_valid, d_rs1, d_rs2, d_rs1_used, d_rs2_used, d_rd, d_rd_we,
           d_lat, d_long, flush,
    output stall, issue, pending, long_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard between decode and execute: RAW, WAW
// and long-unit structural hazards, with a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int MAX_LAT  = 8,
  parameter int PERF_W   = 32
) (
  input  logic clock,
  input  logic reset,
  hazard_scoreboard_if.slave sb
);
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int LAT_W  = $clog2(MAX_LAT + 1);

  logic [LAT_W-1:0]  cnt_q [NUM_REGS];
  logic [LAT_W-1:0]  cnt_d [NUM_REGS];
  logic [LAT_W-1:0]  long_cnt_q, long_cnt_d;
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

  logic [LAT_W-1:0]    lat_c;
  logic                raw1, raw2, waw, structural;
  logic                stall_c, issue_c;
  logic [NUM_REGS-1:0] pending_c;

  always_comb begin
    lat_c = (sb.d_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : sb.d_lat;
    // Sources read the old entry, so rs == rd of the same instruction is safe.
    raw1 = sb.d_rs1_used && (sb.d_rs1 != '0) && (cnt_q[sb.d_rs1] != '0);
    raw2 = sb.d_rs2_used && (sb.d_rs2 != '0) && (cnt_q[sb.d_rs2] != '0);
    waw  = sb.d_rd_we && (sb.d_rd != '0) && (cnt_q[sb.d_rd] > lat_c);
    structural = sb.d_long && (long_cnt_q != '0);
    stall_c = sb.d_valid && !sb.flush && (raw1 || raw2 || waw || structural);
    issue_c = sb.d_valid && !sb.flush && !stall_c;
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
      if (issue_c && sb.d_rd_we && (sb.d_rd == REG_AW'(r)))
        cnt_d[r] = lat_c;
    end
    cnt_d[0] = '0;

    long_cnt_d = (long_cnt_q != '0) ? long_cnt_q - LAT_W'(1) : '0;
    if (issue_c && sb.d_long)
      long_cnt_d = lat_c;

    stall_cycles_d = stall_cycles_q;
    if (stall_c && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + PERF_W'(1);

    for (int r = 0; r < NUM_REGS; r++)
      pending_c[r] = (cnt_q[r] != '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= '0;
      long_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt_q[r] <= cnt_d[r];
      long_cnt_q     <= long_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign sb.stall        = stall_c;
  assign sb.issue        = issue_c;
  assign sb.pending      = pending_c;
  assign sb.long_busy    = (long_cnt_q != '0);
  assign sb.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; a second PERF_W=3 instance shares the
// stimulus to exercise counter saturation.
module tb_hazard_scoreboard;
  logic clock;
  logic reset;
  int   n_chk;
  int   n_pass;
  int   n;

  hazard_scoreboard_if #(.NUM_REGS(32), .MAX_LAT(8), .PERF_W(32)) sb ();
  hazard_scoreboard_if #(.NUM_REGS(32), .MAX_LAT(8), .PERF_W(3))  sb2 ();

  hazard_scoreboard #(.NUM_REGS(32), .MAX_LAT(8), .PERF_W(32)) dut (
    .clock(clock), .reset(reset), .sb(sb)
  );
  hazard_scoreboard #(.NUM_REGS(32), .MAX_LAT(8), .PERF_W(3)) dut_sat (
    .clock(clock), .reset(reset), .sb(sb2)
  );

  assign sb2.d_valid    = sb.d_valid;
  assign sb2.d_rs1      = sb.d_rs1;
  assign sb2.d_rs2      = sb.d_rs2;
  assign sb2.d_rs1_used = sb.d_rs1_used;
  assign sb2.d_rs2_used = sb.d_rs2_used;
  assign sb2.d_rd       = sb.d_rd;
  assign sb2.d_rd_we    = sb.d_rd_we;
  assign sb2.d_lat      = sb.d_lat;
  assign sb2.d_long     = sb.d_long;
  assign sb2.flush      = sb.flush;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input int rs1, input logic u1, input int rs2,
                       input logic u2, input int rd, input logic we, input int lat,
                       input logic lng, input logic fl);
    sb.d_valid    = v;
    sb.d_rs1      = 5'(rs1);
    sb.d_rs1_used = u1;
    sb.d_rs2      = 5'(rs2);
    sb.d_rs2_used = u2;
    sb.d_rd       = 5'(rd);
    sb.d_rd_we    = we;
    sb.d_lat      = 4'(lat);
    sb.d_long     = lng;
    sb.flush      = fl;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b0;
    idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_issue", 32'(sb.issue), 1);
    chk("rst_stall", 32'(sb.stall), 0);
    chk("rst_pending", sb.pending, 0);
    chk("rst_long_busy", 32'(sb.long_busy), 0);
    chk("rst_stall_cycles", sb.stall_cycles, 0);
    idle();
    reset = 1'b1;
    tick();

    // load x5 (lat 1) then add x6, x5, x1
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    chk("load_issue", 32'(sb.issue), 1);
    tick();
    drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    chk("lu_stall", 32'(sb.stall), 1);
    chk("lu_no_issue", 32'(sb.issue), 0);
    chk("lu_pending5", 32'(sb.pending[5]), 1);
    tick();
    chk("lu_issue_t2", 32'(sb.issue), 1);
    chk("lu_stall_cycles", sb.stall_cycles, 1);
    tick();

    // ALU producer: no stall
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    tick();
    drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    chk("alu_no_stall", 32'(sb.stall), 0);
    chk("alu_pending", sb.pending, 0);
    tick();
    idle();

    // long op to x7 lat 6, then addi x7 lat 0: WAW
    drive(1, 0, 0, 0, 0, 7, 1, 6, 1, 0);
    tick();
    drive(1, 1, 1, 0, 0, 7, 1, 0, 0, 0);
    chk("waw_long_busy", 32'(sb.long_busy), 1);
    n = 0;
    for (int i = 0; i < 20 && !sb.issue; i++) begin n++; tick(); end
    chk("waw_stalls", 32'(n), 6);
    chk("waw_issue", 32'(sb.issue), 1);
    tick();
    idle();

    // long op x9 lat 4, then long op x10: structural
    drive(1, 0, 0, 0, 0, 9, 1, 4, 1, 0);
    tick();
    drive(1, 0, 0, 0, 0, 10, 1, 2, 1, 0);
    chk("st_stall", 32'(sb.stall), 1);
    n = 0;
    for (int i = 0; i < 20 && !sb.issue; i++) begin n++; tick(); end
    chk("st_stalls", 32'(n), 4);
    chk("st_long_busy", 32'(sb.long_busy), 0);
    chk("st_stall_cycles", sb.stall_cycles, 11);
    chk("sat_at_11", sb2.stall_cycles, 7);
    tick();
    idle();
    tick(); tick(); tick();

    // flush of a stalled dependent
    drive(1, 0, 0, 0, 0, 5, 1, 3, 0, 0);
    tick();
    drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 1);
    chk("fl_stall", 32'(sb.stall), 0);
    chk("fl_issue", 32'(sb.issue), 0);
    tick();
    chk("fl_pending5", 32'(sb.pending[5]), 1);
    tick();
    drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
    chk("fl_then_stall", 32'(sb.stall), 1);
    tick();
    chk("fl_decrement_issue", 32'(sb.issue), 1);
    chk("fl_stall_cycles", sb.stall_cycles, 12);
    tick();
    idle();

    // write to x0 is never tracked
    drive(1, 0, 0, 0, 0, 0, 1, 4, 0, 0);
    tick();
    drive(1, 0, 1, 0, 1, 6, 1, 0, 0, 0);
    chk("x0_no_stall", 32'(sb.stall), 0);
    chk("x0_pending", sb.pending, 0);
    tick();

    // lat 15 clamps to 8
    drive(1, 0, 0, 0, 0, 11, 1, 15, 0, 0);
    tick();
    idle();
    n = 0;
    for (int i = 0; i < 20 && sb.pending[11]; i++) begin n++; tick(); end
    chk("clamp_cycles", 32'(n), 8);

    // reissue to x12 while old entry expires: new value wins
    drive(1, 0, 0, 0, 0, 12, 1, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 12, 1, 2, 0, 0);
    chk("reissue_issue", 32'(sb.issue), 1);
    tick();
    idle();
    chk("reissue_p_t2", 32'(sb.pending[12]), 1);
    tick();
    chk("reissue_p_t3", 32'(sb.pending[12]), 1);
    tick();
    chk("reissue_p_t4", 32'(sb.pending[12]), 0);

    // rs1 == rd with no prior entry
    drive(1, 13, 1, 0, 0, 13, 1, 3, 0, 0);
    chk("self_dep_issue", 32'(sb.issue), 1);
    tick();
    idle();
    tick(); tick(); tick();

    // reset while x3 pending
    drive(1, 0, 0, 0, 0, 3, 1, 5, 0, 0);
    tick();
    idle();
    chk("pre_rst_pending3", 32'(sb.pending[3]), 1);
    chk("sat_hold", sb2.stall_cycles, 7);
    reset = 1'b0;
    #1;
    chk("mid_rst_pending", sb.pending, 0);
    chk("mid_rst_stall_cycles", sb.stall_cycles, 0);
    chk("mid_rst_sat_cleared", sb2.stall_cycles, 0);
    reset = 1'b1;
    tick();
    drive(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
    chk("post_rst_no_stall", 32'(sb.stall), 0);
    tick();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the in-order RISC-V pipeline. It sits between decode and execute and replaces fixed-latency load-use detection with a per-register pending-write scoreboard. The scoreboard handles any producer latency up to `MAX_LAT`, write-after-write ordering, and occupancy of one non-pipelined long-latency unit such as a divider. It drives the decode stall and the issue strobe, and keeps a stall-cycle performance counter.

## Interface
Parameters:
- `NUM_REGS`, 32: architectural registers tracked; `REG_AW = $clog2(NUM_REGS)`.
- `MAX_LAT`, 8: largest producer latency accepted; `LAT_W = $clog2(MAX_LAT+1)`.
- `PERF_W`, 32: width of the stall-cycle counter.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately on assertion.
- `d_valid`  in  1  decode holds a valid instruction.
- `d_rs1`, `d_rs2`  in  REG_AW  source registers.
- `d_rs1_used`, `d_rs2_used`  in  1  instruction reads that source.
- `d_rd`  in  REG_AW  destination register.
- `d_rd_we`  in  1  instruction writes `d_rd`.
- `d_lat`  in  LAT_W  cycles after issue until the result can be bypassed into X. ALU = 0, load = 1.
- `d_long`  in  1  instruction occupies the non-pipelined long unit.
- `flush`  in  1  decode instruction is being squashed this cycle (taken branch/jump in X).
- `stall`  out  1  hold F/D; insert bubble into X.
- `issue`  out  1  decode instruction advances into X this cycle.
- `pending`  out  NUM_REGS  bit r = 1 while register r has an outstanding write.
- `long_busy`  out  1  long unit occupied.
- `stall_cycles`  out  PERF_W  saturating count of stalled cycles.

## Operation
- State:
  - one `LAT_W` counter `cnt[r]` per register, r = 1..NUM_REGS-1;
  - `long_cnt` (`LAT_W`);
  - `stall_cycles`.
- Register 0 is never tracked. `cnt[0]` reads 0 and `pending[0]` = 0.
- `lat_c` = `min(d_lat, MAX_LAT)`.
- Hazards are evaluated combinationally:
  - RAW: `d_rs1_used && d_rs1 != 0 && cnt[d_rs1] != 0`, and the same check for rs2.
  - WAW: `d_rd_we && d_rd != 0 && cnt[d_rd] > lat_c`. A younger write must not complete before an older one.
  - Structural: `d_long && long_cnt != 0`.
- `stall` = `d_valid && !flush && (RAW || WAW || structural)`.
- `issue` = `d_valid && !flush && !stall`.
- Per-cycle update:
  - every nonzero `cnt[r]` decrements by 1;
  - if `issue && d_rd_we && d_rd != 0`, then `cnt[d_rd] <= lat_c`, overriding that register's decrement;
  - `long_cnt` decrements when nonzero; `issue && d_long` loads `lat_c`.
- An issue with `lat_c = 0` leaves the counter at 0, so there is no pending state and no stall.
- `pending[r]` = `cnt[r] != 0`. `long_busy` = `long_cnt != 0`. Both are derived from registered state only.
- `stall_cycles` increments on each cycle with `stall = 1` and saturates at all-ones.
- `flush` suppresses both `issue` and `stall` for that cycle. Already-issued (older) writes are never cancelled.

## Timing
- Reset values: all `cnt` = 0, `long_cnt` = 0, `stall_cycles` = 0. Consequently `pending` = 0, `long_busy` = 0, `stall` = 0, `issue` = `d_valid`.
- Reset asserted mid-operation discards all outstanding entries at once. The first cycle after deassertion has no hazards.
- `stall` and `issue` are combinational, with zero-cycle latency from decode inputs.
- Producer issued in cycle t with latency L:
  - `cnt` = L in cycle t+1, decrementing to 0 in cycle t+1+L;
  - a dependent instruction in decode at t+1 stalls exactly L cycles and issues in cycle t+1+L.
- Simultaneous issue to rd and expiry of rd's old entry: the new value wins.
- A source equal to the `d_rd` of the same instruction checks the old entry only.
- A long op with L issues at t; the next long op can issue at t+1+L.
- `d_lat > MAX_LAT` is clamped to `MAX_LAT`; no error is flagged.

## Test plan
- Reset, then `d_valid` = 1 with no sources used -> `issue` = 1, `stall` = 0, `pending` = 0, `stall_cycles` = 0.
- Load x5 (`d_lat` = 1) issued at t, then `add x6, x5, x1` in decode at t+1 -> `stall` = 1 for exactly one cycle, `issue` at t+2, `stall_cycles` = 1. The same sequence with an ALU producer (`d_lat` = 0) -> no stall.
- Long op to x7 with `d_lat` = 6, then `addi x7` with `d_lat` = 0 -> WAW stall for 6 cycles. A second long op in that window -> structural stall until `long_busy` falls.
- Dependent instruction stalled on x5 with `flush` = 1 -> `stall` = 0, `issue` = 0, `cnt[x5]` keeps decrementing.
- `d_rd` = 0 with `d_lat` = 4, then a reader of x0 -> no stall. `d_lat` = 15 with `MAX_LAT` = 8 -> `pending` held for 8 cycles.
- Assert `reset` while `cnt[x3]` = 5 -> `pending` = 0 immediately. Force more than 2^PERF_W stall cycles in a reduced-`PERF_W` build -> counter holds all-ones.
